// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3-kernel / 4x4-image valid-mode
// convolution sequencer.
//   state_t   : sequencer FSM states
//   IMG_DIM   : image side length (pixels)
//   K_DIM     : kernel side length
//   OUT_DIM   : output map side length (valid-mode convolution)
//   DATA_W    : pixel / kernel word width
//   ACC_W     : accumulator and result width (9 * 15 * 15 = 2025 fits)
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int IMG_DIM = 4;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int DATA_W  = 4;
  localparam int ACC_W   = 11;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int ADDR_W  = 4;

  // Kernel row/column counters span 0..2, output row/column counters 0..1.
  localparam int K_IDX_W = 2;
  localparam int O_IDX_W = 1;

  localparam logic [K_IDX_W-1:0] K_LAST = K_IDX_W'(K_DIM - 1);
  localparam logic [O_IDX_W-1:0] O_LAST = O_IDX_W'(OUT_DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_addr_gen
// Combinational address generator. Maps the kernel position (k_row, k_col)
// and the output pixel (o_row, o_col) onto the kernel ROM address and the
// row-major image store address.
//   k_row, k_col  in  kernel row / column (0..2)
//   o_row, o_col  in  output row / column (0..1)
//   kernel_addr   out k_row*3 + k_col
//   pixel_addr    out (o_row+k_row)*4 + (o_col+k_col)
// ---------------------------------------------------------------------------
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic [K_IDX_W-1:0] k_row,
  input  logic [K_IDX_W-1:0] k_col,
  input  logic [O_IDX_W-1:0] o_row,
  input  logic [O_IDX_W-1:0] o_col,
  output logic [ADDR_W-1:0]  kernel_addr,
  output logic [ADDR_W-1:0]  pixel_addr
);

  logic [ADDR_W-1:0] k_row_ext;
  logic [ADDR_W-1:0] k_col_ext;
  logic [ADDR_W-1:0] img_row;
  logic [ADDR_W-1:0] img_col;

  // Multiplies by 3 and 4 are built from a shift plus add so no multiplier,
  // divider or modulo is ever inferred.
  always_comb begin
    k_row_ext   = {2'b00, k_row};
    k_col_ext   = {2'b00, k_col};
    img_row     = {3'b000, o_row} + k_row_ext;
    img_col     = {3'b000, o_col} + k_col_ext;
    kernel_addr = (k_row_ext << 1) + k_row_ext + k_col_ext;
    pixel_addr  = (img_row << 2) + img_col;
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// ---------------------------------------------------------------------------
// conv_mac_sequencer
// Walks one valid-mode 3x3 convolution over a 4x4 image, producing the 2x2
// output map in order (0,0), (0,1), (1,0), (1,1). Each output pixel takes 9
// MAC cycles and one EMIT cycle; a DONE strobe closes the frame.
//   CLK          in  clock, rising edge
//   CLR          in  synchronous active-high reset
//   start        in  begin a frame (only honoured in IDLE)
//   kernel_addr  out kernel ROM address (0 outside MAC)
//   kernel_data  in  kernel word, combinational read of kernel_addr
//   pixel_addr   out image store address (0 outside MAC)
//   pixel_data   in  pixel word, combinational read of pixel_addr
//   result       out last completed output pixel
//   result_idx   out {o_row, o_col} of result
//   result_valid out one-cycle strobe while the new result is presented
//   busy         out frame in progress
//   done         out one-cycle strobe after the fourth result
// ---------------------------------------------------------------------------
module conv_mac_sequencer
  import conv_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  output logic [ADDR_W-1:0] kernel_addr,
  input  logic [DATA_W-1:0] kernel_data,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [DATA_W-1:0] pixel_data,
  output logic [ACC_W-1:0]  result,
  output logic [1:0]        result_idx,
  output logic              result_valid,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;

  logic [K_IDX_W-1:0] k_row_q, k_row_d;
  logic [K_IDX_W-1:0] k_col_q, k_col_d;
  logic [O_IDX_W-1:0] o_row_q, o_row_d;
  logic [O_IDX_W-1:0] o_col_q, o_col_d;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic [1:0]        result_idx_q, result_idx_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] kernel_addr_q, kernel_addr_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;

  logic [PROD_W-1:0] prod;
  logic [ADDR_W-1:0] gen_kernel_addr;
  logic [ADDR_W-1:0] gen_pixel_addr;

  // Addresses are generated from the next-cycle counters and registered, so
  // the ROM data seen in a MAC cycle always belongs to that cycle's k.
  conv_addr_gen u_addr_gen (
    .k_row       (k_row_d),
    .k_col       (k_col_d),
    .o_row       (o_row_d),
    .o_col       (o_col_d),
    .kernel_addr (gen_kernel_addr),
    .pixel_addr  (gen_pixel_addr)
  );

  assign prod = {{DATA_W{1'b0}}, kernel_data} * {{DATA_W{1'b0}}, pixel_data};

  // Next-state, counter and datapath logic. result/result_idx/result_valid
  // are loaded on the edge that enters EMIT so they are presented during
  // the EMIT cycle itself; likewise done is loaded on the edge into DONE.
  always_comb begin
    state_d        = state_q;
    k_row_d        = k_row_q;
    k_col_d        = k_col_q;
    o_row_d        = o_row_q;
    o_col_d        = o_col_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_idx_d   = result_idx_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          k_row_d = '0;
          k_col_d = '0;
          o_row_d = '0;
          o_col_d = '0;
        end
      end

      MAC: begin
        // The first tap overwrites the accumulator, so no clear cycle is
        // needed between output pixels.
        if (k_row_q == '0 && k_col_q == '0) begin
          acc_d = {{(ACC_W-PROD_W){1'b0}}, prod};
        end else begin
          acc_d = acc_q + {{(ACC_W-PROD_W){1'b0}}, prod};
        end

        if (k_col_q == K_LAST) begin
          k_col_d = '0;
          if (k_row_q == K_LAST) begin
            k_row_d        = '0;
            state_d        = EMIT;
            result_d       = acc_d;
            result_idx_d   = {o_row_q, o_col_q};
            result_valid_d = 1'b1;
          end else begin
            k_row_d = k_row_q + 1'b1;
          end
        end else begin
          k_col_d = k_col_q + 1'b1;
        end
      end

      EMIT: begin
        if (o_row_q == O_LAST && o_col_q == O_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = MAC;
          if (o_col_q == O_LAST) begin
            o_col_d = '0;
            o_row_d = o_row_q + 1'b1;
          end else begin
            o_col_d = o_col_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d        = (state_d != IDLE);
    kernel_addr_d = (state_d == MAC) ? gen_kernel_addr : '0;
    pixel_addr_d  = (state_d == MAC) ? gen_pixel_addr  : '0;
  end

  // State register; CLR returns everything to its idle values on the next
  // edge, which also suppresses any strobe for an aborted frame.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q        <= IDLE;
      k_row_q        <= '0;
      k_col_q        <= '0;
      o_row_q        <= '0;
      o_col_q        <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_idx_q   <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      kernel_addr_q  <= '0;
      pixel_addr_q   <= '0;
    end else begin
      state_q        <= state_d;
      k_row_q        <= k_row_d;
      k_col_q        <= k_col_d;
      o_row_q        <= o_row_d;
      o_col_q        <= o_col_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_idx_q   <= result_idx_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      kernel_addr_q  <= kernel_addr_d;
      pixel_addr_q   <= pixel_addr_d;
    end
  end

  assign kernel_addr  = kernel_addr_q;
  assign pixel_addr   = pixel_addr_q;
  assign result       = result_q;
  assign result_idx   = result_idx_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_sequencer
// Directed bench for conv_mac_sequencer. The kernel ROM and image store are
// modelled as bench arrays read combinationally. Cycle n is the clock period
// following edge n-1, where edge 0 is the edge that samples start.
// ---------------------------------------------------------------------------
module tb_conv_mac_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  kernel_addr;
  logic [3:0]  kernel_data;
  logic [3:0]  pixel_addr;
  logic [3:0]  pixel_data;
  logic [10:0] result;
  logic [1:0]  result_idx;
  logic        result_valid;
  logic        busy;
  logic        done;

  logic [3:0]  krom [0:15];
  logic [3:0]  img  [0:15];

  // Per-cycle observations, indexed by cycle number after edge 0.
  logic        obs_valid  [0:127];
  logic        obs_done   [0:127];
  logic        obs_busy   [0:127];
  logic [10:0] obs_result [0:127];
  logic [1:0]  obs_idx    [0:127];
  logic [3:0]  obs_kaddr  [0:127];
  logic [3:0]  obs_paddr  [0:127];

  int errors = 0;
  int checks = 0;

  conv_mac_sequencer dut (
    .CLK          (clock),
    .CLR          (reset),
    .start        (start),
    .kernel_addr  (kernel_addr),
    .kernel_data  (kernel_data),
    .pixel_addr   (pixel_addr),
    .pixel_data   (pixel_data),
    .result       (result),
    .result_idx   (result_idx),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Zero-latency ROM / image store models.
  always_comb begin
    kernel_data = krom[kernel_addr];
    pixel_data  = img[pixel_addr];
  end

  // Loads the 1,2,1,0,1,2,1,0,1 kernel; unused ROM words read as zero.
  task automatic load_std_kernel();
    logic [3:0] k [0:8];
    k = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd1};
    for (int i = 0; i < 16; i++) krom[i] = (i < 9) ? k[i] : 4'd0;
  endtask

  task automatic load_ramp_image();
    for (int i = 0; i < 16; i++) img[i] = 4'(i);
  endtask

  // Runs n cycles from a negedge where start has just been set, recording
  // outputs at each following negedge. Unless hold is set, start drops
  // right after edge 0.
  task automatic applyStimulus(input int n, input bit hold);
    for (int cyc = 1; cyc <= n; cyc++) begin
      @(posedge clock);
      #1;
      if (!hold) start = 1'b0;
      @(negedge clock);
      obs_valid[cyc]  = result_valid;
      obs_done[cyc]   = done;
      obs_busy[cyc]   = busy;
      obs_result[cyc] = result;
      obs_idx[cyc]    = result_idx;
      obs_kaddr[cyc]  = kernel_addr;
      obs_paddr[cyc]  = pixel_addr;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    load_std_kernel();
    load_ramp_image();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (result !== 11'd0) begin errors++; $display("[TB] FAIL reset_result got=%0d want=0", result); end
    checks++;
    if (result_idx !== 2'd0 || result_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idx_valid got=%0d/%0b want=0/0", result_idx, result_valid);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy_done got=%0b/%0b want=0/0", busy, done);
    end
    checks++;
    if (kernel_addr !== 4'd0 || pixel_addr !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_addr got=%0d/%0d want=0/0", kernel_addr, pixel_addr);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ones_frame();
    int cnt;
    load_std_kernel();
    for (int i = 0; i < 16; i++) img[i] = 4'd1;
    start = 1'b1;
    applyStimulus(42, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs_valid[10*n+10] !== 1'b1 || obs_result[10*n+10] !== 11'd9 || obs_idx[10*n+10] !== 2'(n)) begin
        errors++;
        $display("[TB] FAIL ones_result%0d got=%0b/%0d/%0d want=1/9/%0d", n,
                 obs_valid[10*n+10], obs_result[10*n+10], obs_idx[10*n+10], n);
      end
    end
    cnt = 0;
    for (int c = 1; c <= 42; c++) if (obs_valid[c] === 1'b1) cnt++;
    checks++;
    if (cnt !== 4) begin errors++; $display("[TB] FAIL ones_valid_count got=%0d want=4", cnt); end
    cnt = 0;
    for (int c = 1; c <= 42; c++) if (obs_done[c] === 1'b1) cnt++;
    checks++;
    if (obs_done[41] !== 1'b1 || cnt !== 1) begin
      errors++; $display("[TB] FAIL ones_done got=%0b count=%0d want=1 count=1", obs_done[41], cnt);
    end
    cnt = 0;
    for (int c = 1; c <= 41; c++) if (obs_busy[c] !== 1'b1) cnt++;
    checks++;
    if (cnt !== 0 || obs_busy[42] !== 1'b0) begin
      errors++; $display("[TB] FAIL ones_busy got=%0d low cycles, busy42=%0b want=0, 0", cnt, obs_busy[42]);
    end
    checks++;
    if (obs_kaddr[10] !== 4'd0 || obs_paddr[10] !== 4'd0 || obs_kaddr[42] !== 4'd0 || obs_paddr[42] !== 4'd0) begin
      errors++; $display("[TB] FAIL ones_addr_idle got=%0d/%0d want=0/0", obs_kaddr[10], obs_paddr[10]);
    end
  endtask

  task automatic test_ramp_frame();
    logic [10:0] exp_res [0:3];
    logic [3:0]  exp_pad [0:8];
    exp_res = '{11'd39, 11'd48, 11'd75, 11'd84};
    exp_pad = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    load_std_kernel();
    load_ramp_image();
    start = 1'b1;
    applyStimulus(42, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs_valid[10*n+10] !== 1'b1 || obs_result[10*n+10] !== exp_res[n] || obs_idx[10*n+10] !== 2'(n)) begin
        errors++;
        $display("[TB] FAIL ramp_result%0d got=%0b/%0d/%0d want=1/%0d/%0d", n,
                 obs_valid[10*n+10], obs_result[10*n+10], obs_idx[10*n+10], exp_res[n], n);
      end
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs_kaddr[31+k] !== 4'(k) || obs_paddr[31+k] !== exp_pad[k]) begin
        errors++;
        $display("[TB] FAIL addr_trace_k%0d got=%0d/%0d want=%0d/%0d", k,
                 obs_kaddr[31+k], obs_paddr[31+k], k, exp_pad[k]);
      end
    end
    checks++;
    if (obs_result[19] !== 11'd39) begin
      errors++; $display("[TB] FAIL ramp_result_hold got=%0d want=39", obs_result[19]);
    end
  endtask

  task automatic test_max_frame();
    for (int i = 0; i < 16; i++) begin
      krom[i] = (i < 9) ? 4'd15 : 4'd0;
      img[i]  = 4'd15;
    end
    start = 1'b1;
    applyStimulus(42, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs_valid[10*n+10] !== 1'b1 || obs_result[10*n+10] !== 11'd2025) begin
        errors++;
        $display("[TB] FAIL max_result%0d got=%0b/%0d want=1/2025", n, obs_valid[10*n+10], obs_result[10*n+10]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_res [0:3];
    int cnt_valid;
    int cnt_done;
    int bad_busy;
    exp_res = '{11'd39, 11'd48, 11'd75, 11'd84};
    load_std_kernel();
    load_ramp_image();
    start = 1'b1;
    applyStimulus(126, 1'b1);
    start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (obs_valid[42*f+10*n+10] !== 1'b1 || obs_result[42*f+10*n+10] !== exp_res[n]) begin
          errors++;
          $display("[TB] FAIL b2b_f%0d_r%0d got=%0b/%0d want=1/%0d", f, n,
                   obs_valid[42*f+10*n+10], obs_result[42*f+10*n+10], exp_res[n]);
        end
      end
    end
    cnt_valid = 0;
    cnt_done  = 0;
    bad_busy  = 0;
    for (int c = 1; c <= 126; c++) begin
      if (obs_valid[c] === 1'b1) cnt_valid++;
      if (obs_done[c] === 1'b1) cnt_done++;
      if (obs_busy[c] !== ((c % 42) != 0)) bad_busy++;
    end
    checks++;
    if (cnt_valid !== 12) begin errors++; $display("[TB] FAIL b2b_valid_count got=%0d want=12", cnt_valid); end
    checks++;
    if (cnt_done !== 3 || obs_done[83] !== 1'b1 || obs_done[125] !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_done got=%0d strobes want=3 at 41/83/125", cnt_done);
    end
    checks++;
    if (bad_busy !== 0) begin errors++; $display("[TB] FAIL b2b_busy got=%0d wrong cycles want=0", bad_busy); end
    @(negedge clock);
  endtask

  task automatic test_clear_mid_frame();
    logic [10:0] exp_res [0:3];
    int cnt;
    exp_res = '{11'd39, 11'd48, 11'd75, 11'd84};
    load_std_kernel();
    load_ramp_image();
    start = 1'b1;
    applyStimulus(15, 1'b0);
    checks++;
    if (obs_busy[15] !== 1'b1 || obs_kaddr[15] !== 4'd4) begin
      errors++; $display("[TB] FAIL clr_pre_state got=%0b/%0d want=1/4", obs_busy[15], obs_kaddr[15]);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (result !== 11'd0 || result_idx !== 2'd0 || result_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0
        || kernel_addr !== 4'd0 || pixel_addr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL clr_outputs got=%0d/%0d/%0b/%0b/%0b/%0d/%0d want=all 0", result, result_idx,
               result_valid, busy, done, kernel_addr, pixel_addr);
    end
    reset = 1'b0;
    applyStimulus(30, 1'b0);
    cnt = 0;
    for (int c = 1; c <= 30; c++) if (obs_valid[c] === 1'b1 || obs_done[c] === 1'b1 || obs_busy[c] === 1'b1) cnt++;
    checks++;
    if (cnt !== 0) begin errors++; $display("[TB] FAIL clr_quiet got=%0d active cycles want=0", cnt); end
    start = 1'b1;
    applyStimulus(42, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (obs_valid[10*n+10] !== 1'b1 || obs_result[10*n+10] !== exp_res[n] || obs_idx[10*n+10] !== 2'(n)) begin
        errors++;
        $display("[TB] FAIL clr_restart_r%0d got=%0b/%0d/%0d want=1/%0d/%0d", n,
                 obs_valid[10*n+10], obs_result[10*n+10], obs_idx[10*n+10], exp_res[n], n);
      end
    end
    checks++;
    if (obs_done[41] !== 1'b1 || obs_busy[42] !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_restart_done got=%0b/%0b want=1/0", obs_done[41], obs_busy[42]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    $display("[TB] starting conv_mac_sequencer bench");
    test_reset();
    test_ones_frame();
    test_ramp_frame();
    test_max_frame();
    test_back_to_back();
    test_clear_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_mac_sequencer.md
# conv_mac_sequencer

Drives the 3×3 kernel ROM and the 4×4 image store through one valid-mode convolution pass, producing the 2×2 output map. For each output pixel it walks kernel addresses 0–8 and the matching image addresses, multiply-accumulates unsigned 4-bit × 4-bit products, and emits one result with a valid strobe. It sits directly downstream of the kernel ROM and image store, and upstream of the result register/display stage.

## Interface
- IMG_DIM, 4, image side length (pixels)
- K_DIM, 3, kernel side length
- DATA_W, 4, pixel and kernel word width
- ACC_W, 11, accumulator/result width (covers 9·15·15 = 2025)
- Only the default parameter values are verified.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  reset: synchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- kernel_addr  out  4  address to kernel ROM (0–8)
- kernel_data  in  4  kernel word; combinational read of kernel_addr, same cycle
- pixel_addr  out  4  image address, row-major: row·4 + col
- pixel_data  in  4  pixel word; combinational read of pixel_addr, same cycle
- result  out  ACC_W  last completed output pixel
- result_idx  out  2  output index {o_row, o_col} of result
- result_valid  out  1  one-cycle strobe when result updates
- busy  out  1  frame in progress
- done  out  1  one-cycle strobe after the 4th result

## Operation
- States: IDLE, MAC, EMIT, DONE.
- IDLE: start=1 → MAC with k=0, o_row=o_col=0. start=0 → stay.
- MAC: k counts 0..8 as (k_row, k_col). kernel_addr = k_row·3 + k_col; pixel_addr = (o_row+k_row)·4 + (o_col+k_col).
  - k=0: acc ← kernel_data·pixel_data. This discards the previous sum; there is no separate clear cycle.
  - k>0: acc ← acc + kernel_data·pixel_data.
  - After k=8 → EMIT.
- EMIT: result ← acc, result_idx ← {o_row,o_col}, result_valid=1.
  - Output order (0,0), (0,1), (1,0), (1,1).
  - If not the last output: advance o_col (wrap → o_row+1), k←0, → MAC.
  - Last output → DONE.
- DONE: done=1 for one cycle, → IDLE.
- Arithmetic: unsigned only. Product 8 bits, zero-extended to ACC_W. Overflow is impossible at the defaults.
- Outside MAC, kernel_addr and pixel_addr hold 0.
- result and result_idx hold their values until the next EMIT or CLR.
- start while not in IDLE is ignored. start held high runs back-to-back frames, each started from IDLE.
- CLR in any state, including mid-frame: on the next edge, return to IDLE with all reset values. No result_valid or done for the aborted frame.
- Reset values: state IDLE, kernel_addr 0, pixel_addr 0, acc 0, result 0, result_idx 0, result_valid 0, busy 0, done 0.

## Timing
- Edge 0: start sampled in IDLE.
- Output pixel n (n = 0..3): MAC during cycles 10n+1 … 10n+9; EMIT (result_valid=1) at cycle 10n+10.
  - result_valid is therefore high at cycles 10, 20, 30, 40.
- done=1 at cycle 41. IDLE from cycle 42; earliest next start is sampled at edge 42.
- busy=1 in MAC, EMIT and DONE (cycles 1–41); 0 in IDLE.
- Latency start → first result: 10 cycles. Frame: 42 cycles start-to-start.
- ROM reads are zero-latency: addresses are registered outputs, and data is used in the same cycle.

## Structure
- Package conv_pkg holds:
  - state enum {IDLE, MAC, EMIT, DONE}
  - constants IMG_DIM, K_DIM, OUT_DIM = IMG_DIM−K_DIM+1, DATA_W, ACC_W
- Sub-module conv_addr_gen: combinational; (k_row, k_col, o_row, o_col) → kernel_addr, pixel_addr.
  - Uses row/column counters with add/shift only; no divide or modulo.
- Top level holds the FSM, counters, acc and result registers.

## Test plan
- Kernel model 1,2,1,0,1,2,1,0,1 and image all 1s, pulse start → results 9,9,9,9 at cycles 10/20/30/40 with idx 0,1,2,3; done at 41; busy low at 42.
- Same kernel, image pixel[i] = i → results 39, 48, 75, 84 in index order 0–3.
- Kernel all 15, image all 15 → every result 2025; no wrap.
- start held high for 100 cycles → frames start at edges 0, 42, 84; start during busy changes nothing; each frame gives 39, 48, 75, 84.
- CLR at cycle 15 (mid second MAC) → cycle 16: all outputs at reset values, no further result_valid/done; a new start then yields 39, 48, 75, 84 with correct timing.
- Address trace for output (1,1) → pixel_addr sequence 5,6,7,9,10,11,13,14,15, paired with kernel_addr 0..8.
